// File: rtl/xgmii_tx_decoder_if.sv
// Bus bundle for xgmii_tx_decoder: XGMII transmit lanes in, decoded packet stream and counters out.
// master = stimulus side driving XGMII; slave = decoder.
interface xgmii_tx_decoder_if #(
  parameter int CNT_W     = 32,
  parameter int ERR_CNT_W = 16
);
  logic [7:0]           xgmii_txc;
  logic [63:0]          xgmii_txd;
  logic                 dec_val;
  logic [63:0]          dec_data;
  logic                 dec_sop;
  logic                 dec_eop;
  logic [2:0]           dec_mod;
  logic                 dec_err;
  logic [CNT_W-1:0]     frame_cnt;
  logic [ERR_CNT_W-1:0] err_cnt;

  modport master (
    output xgmii_txc, xgmii_txd,
    input  dec_val, dec_data, dec_sop, dec_eop, dec_mod, dec_err, frame_cnt, err_cnt
  );

  modport slave (
    input  xgmii_txc, xgmii_txd,
    output dec_val, dec_data, dec_sop, dec_eop, dec_mod, dec_err, frame_cnt, err_cnt
  );
endinterface

// File: rtl/xgmii_tx_decoder.sv
// XGMII TX decoder: finds Start, checks and strips preamble/SFD, repacks frame bytes to 64-bit words.
// Optional macro XGE_DEC_CRC_CHECK_EN adds an FCS residue check on every eop word.
module xgmii_tx_decoder #(
  parameter int CNT_W     = 32,
  parameter int ERR_CNT_W = 16
) (
  input logic               clkXGMIITx,
  input logic               reset_xgmii_tx_n,
  xgmii_tx_decoder_if.slave bus
);
  localparam logic [7:0] C_FB = 8'hFB, C_FD = 8'hFD, C_FE = 8'hFE, C_IDLE = 8'h07;

  typedef enum logic [2:0] {IDLE, PRE_HI, DATA, FLUSH, DROP} state_t;

  state_t               r_state, w_state_nx;
  logic [127:0]         r_stage, w_stage_nx, w_app;
  logic [4:0]           r_cnt, w_cnt_nx, w_app_cnt;
  logic                 r_sop_pend, w_sop_nx;
  logic                 r_val, r_sop, r_eop, r_err;
  logic [63:0]          r_data;
  logic [2:0]           r_mod;
  logic [CNT_W-1:0]     r_frame_cnt;
  logic [ERR_CNT_W-1:0] r_err_cnt;
  logic                 w_emit, w_emit_eop, w_emit_err;
  logic [63:0]          w_emit_data;
  logic [2:0]           w_emit_mod;
  logic [1:0]           w_err_inc;
  logic [7:0]           w_lane [8];
  logic [7:0]           w_above;
  logic [3:0]           w_t;
  logic                 w_fb_any, w_fe_any, w_fd_any, w_all_idle;
  logic                 w_term_ok, w_start0, w_start4, w_pre_hi_ok;

  // Byte k of the staging buffer lives at [127-8k -: 8]; appended bytes come from lanes 0..n-1.
  function automatic logic [127:0] f_append(input logic [127:0] b, input logic [4:0] c,
                                            input logic [63:0] w, input logic [3:0] n);
    logic [127:0] r;
    r = b;
    for (int k = 0; k < 8; k++)
      if (k < int'(n)) r[127-8*(int'(c)+k) -: 8] = w[8*k +: 8];
    return r;
  endfunction

  function automatic logic [63:0] f_mask(input logic [63:0] d, input logic [4:0] n);
    logic [63:0] r;
    r = d;
    for (int k = 0; k < 8; k++)
      if (k >= int'(n)) r[63-8*k -: 8] = 8'h00;
    return r;
  endfunction

  function automatic logic [ERR_CNT_W-1:0] f_sat_add(input logic [ERR_CNT_W-1:0] a,
                                                     input logic [1:0] inc);
    logic [ERR_CNT_W:0] s;
    s = {1'b0, a} + {{(ERR_CNT_W-1){1'b0}}, inc};
    return s[ERR_CNT_W] ? '1 : s[ERR_CNT_W-1:0];
  endfunction

`ifdef XGE_DEC_CRC_CHECK_EN
  localparam logic [31:0] C_RESIDUE = 32'hC704DD7B;
  logic [31:0] r_crc, w_crc_nx;

  function automatic logic [31:0] f_crc_upd(input logic [31:0] crc, input logic [63:0] w,
                                            input logic [3:0] n);
    logic [31:0] c;
    c = crc;
    for (int k = 0; k < 8; k++)
      if (k < int'(n))
        for (int b = 0; b < 8; b++)
          c = (c[0] ^ w[8*k+b]) ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    return c;
  endfunction

  // The engine runs reflected; the residue constant is in normal bit order.
  function automatic logic f_crc_bad(input logic [31:0] crc);
    logic [31:0] r;
    for (int i = 0; i < 32; i++) r[i] = crc[31-i];
    return r != C_RESIDUE;
  endfunction
`endif

  always_comb begin
    w_fb_any   = 1'b0;
    w_fe_any   = 1'b0;
    w_fd_any   = 1'b0;
    w_all_idle = (bus.xgmii_txc == 8'hFF);
    w_t        = 4'd8;
    for (int i = 0; i < 8; i++) begin
      w_lane[i] = bus.xgmii_txd[8*i +: 8];
      if (bus.xgmii_txc[i]) begin
        if (w_lane[i] == C_FB) w_fb_any = 1'b1;
        if (w_lane[i] == C_FE) w_fe_any = 1'b1;
        if (w_lane[i] == C_FD) w_fd_any = 1'b1;
      end
      if (w_lane[i] != C_IDLE) w_all_idle = 1'b0;
    end
    for (int i = 7; i >= 0; i--)
      if (bus.xgmii_txc[i]) w_t = 4'(i);
  end

  // A terminate needs FD on the lowest control lane and control on every lane above it.
  assign w_above     = 8'hFF << w_t;
  assign w_term_ok   = (w_t != 4'd8) && (w_lane[w_t[2:0]] == C_FD) &&
                       ((bus.xgmii_txc & w_above) == w_above) && !w_fe_any && !w_fb_any;
  assign w_start0    = (bus.xgmii_txc == 8'h01) && (bus.xgmii_txd == 64'hD555_5555_5555_55FB);
  assign w_start4    = (bus.xgmii_txc == 8'h1F) && (bus.xgmii_txd[63:32] == 32'h5555_55FB);
  assign w_pre_hi_ok = (bus.xgmii_txc[3:0] == 4'h0) && (bus.xgmii_txd[31:0] == 32'hD555_5555);
  assign w_app       = f_append(r_stage, r_cnt, bus.xgmii_txd, w_t);
  assign w_app_cnt   = r_cnt + {1'b0, w_t};

  always_comb begin
    w_state_nx  = r_state;
    w_stage_nx  = r_stage;
    w_cnt_nx    = r_cnt;
    w_sop_nx    = r_sop_pend;
    w_emit      = 1'b0;
    w_emit_data = '0;
    w_emit_eop  = 1'b0;
    w_emit_mod  = '0;
    w_emit_err  = 1'b0;
    w_err_inc   = '0;
`ifdef XGE_DEC_CRC_CHECK_EN
    w_crc_nx    = r_crc;
`endif
    unique case (r_state)
      IDLE: begin
        if (w_start0 || w_start4) begin
          w_state_nx = w_start0 ? DATA : PRE_HI;
          w_cnt_nx   = '0;
          w_sop_nx   = 1'b1;
`ifdef XGE_DEC_CRC_CHECK_EN
          w_crc_nx   = 32'hFFFF_FFFF;
`endif
        end else if (w_fb_any) begin
          w_err_inc  = 2'd1;
          w_state_nx = DROP;
        end
      end
      PRE_HI: begin
        if (w_pre_hi_ok) begin
          w_stage_nx = {w_lane[4], w_lane[5], w_lane[6], w_lane[7], 96'h0};
          w_cnt_nx   = 5'd4;
          w_state_nx = DATA;
`ifdef XGE_DEC_CRC_CHECK_EN
          w_crc_nx   = f_crc_upd(r_crc, {32'h0, bus.xgmii_txd[63:32]}, 4'd4);
`endif
        end else begin
          w_err_inc  = 2'd1;
          w_state_nx = DROP;
        end
      end
      DATA: begin
        if ((bus.xgmii_txc == 8'h00) || w_term_ok) begin
          w_stage_nx = w_app;
          w_cnt_nx   = w_app_cnt;
`ifdef XGE_DEC_CRC_CHECK_EN
          w_crc_nx   = f_crc_upd(r_crc, bus.xgmii_txd, w_t);
`endif
          if (w_app_cnt > 5'd8) begin
            w_emit      = 1'b1;
            w_emit_data = w_app[127:64];
            w_stage_nx  = w_app << 64;
            w_cnt_nx    = w_app_cnt - 5'd8;
            if (w_term_ok) w_state_nx = FLUSH;
          end else if (w_term_ok) begin
            w_state_nx = IDLE;
            if (w_app_cnt == 5'd0) begin
              w_err_inc = 2'd1;
            end else begin
              w_emit      = 1'b1;
              w_emit_eop  = 1'b1;
              w_emit_data = f_mask(w_app[127:64], w_app_cnt);
              w_emit_mod  = w_app_cnt[2:0];
`ifdef XGE_DEC_CRC_CHECK_EN
              w_emit_err  = f_crc_bad(w_crc_nx);
              w_err_inc   = {1'b0, w_emit_err};
`endif
            end
          end
        end else begin
          // Aborted frame: close it with whatever is staged, flagged bad.
          w_err_inc  = 2'd1;
          w_state_nx = DROP;
          if (r_cnt != 5'd0) begin
            w_emit      = 1'b1;
            w_emit_eop  = 1'b1;
            w_emit_err  = 1'b1;
            w_emit_data = f_mask(r_stage[127:64], r_cnt);
            w_emit_mod  = r_cnt[2:0];
          end
        end
      end
      FLUSH: begin
        w_emit      = 1'b1;
        w_emit_eop  = 1'b1;
        w_emit_data = f_mask(r_stage[127:64], r_cnt);
        w_emit_mod  = r_cnt[2:0];
        w_err_inc   = {1'b0, w_fb_any};
        w_state_nx  = IDLE;
`ifdef XGE_DEC_CRC_CHECK_EN
        w_emit_err  = f_crc_bad(r_crc);
        w_err_inc   = {1'b0, w_fb_any} + {1'b0, w_emit_err};
`endif
      end
      DROP: begin
        if (w_fd_any || w_all_idle) w_state_nx = IDLE;
      end
      default: w_state_nx = IDLE;
    endcase
    if (w_emit) w_sop_nx = 1'b0;
  end

  always_ff @(posedge clkXGMIITx) begin
    if (!reset_xgmii_tx_n) begin
      r_state     <= IDLE;
      r_stage     <= '0;
      r_cnt       <= '0;
      r_sop_pend  <= 1'b0;
      r_val       <= 1'b0;
      r_data      <= '0;
      r_sop       <= 1'b0;
      r_eop       <= 1'b0;
      r_mod       <= '0;
      r_err       <= 1'b0;
      r_frame_cnt <= '0;
      r_err_cnt   <= '0;
`ifdef XGE_DEC_CRC_CHECK_EN
      r_crc       <= 32'hFFFF_FFFF;
`endif
    end else begin
      r_state    <= w_state_nx;
      r_stage    <= w_stage_nx;
      r_cnt      <= w_cnt_nx;
      r_sop_pend <= w_sop_nx;
      r_val      <= w_emit;
      r_data     <= w_emit_data;
      r_sop      <= w_emit & r_sop_pend;
      r_eop      <= w_emit & w_emit_eop;
      r_mod      <= w_emit_mod;
      r_err      <= w_emit & w_emit_eop & w_emit_err;
      if (w_emit && w_emit_eop && !w_emit_err) r_frame_cnt <= r_frame_cnt + CNT_W'(1);
      r_err_cnt  <= f_sat_add(r_err_cnt, w_err_inc);
`ifdef XGE_DEC_CRC_CHECK_EN
      r_crc      <= w_crc_nx;
`endif
    end
  end

  assign bus.dec_val   = r_val;
  assign bus.dec_data  = r_data;
  assign bus.dec_sop   = r_sop;
  assign bus.dec_eop   = r_eop;
  assign bus.dec_mod   = r_mod;
  assign bus.dec_err   = r_err;
  assign bus.frame_cnt = r_frame_cnt;
  assign bus.err_cnt   = r_err_cnt;
endmodule

// File: tb/tb_xgmii_tx_decoder.sv
// Scoreboard bench for xgmii_tx_decoder: directed XGMII frames in, expected packet words queued
// at stimulus time and popped by an independent monitor on the falling clock edge.
module tb_xgmii_tx_decoder;
  typedef struct packed {
    logic [63:0] data;
    logic        sop;
    logic        eop;
    logic [2:0]  mod;
    logic        err;
  } exp_t;

`ifdef XGE_DEC_CRC_CHECK_EN
  localparam bit CRC_EN = 1'b1;
`else
  localparam bit CRC_EN = 1'b0;
`endif

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  int         errors = 0, checks = 0;
  int         cyc = 0, last_cyc = 0, prev_cyc = 0;
  int         exp_frames = 0, exp_errs = 0;
  exp_t       exp_q[$];
  logic [8:0] strm[$];
  logic [7:0] frm[$];

  xgmii_tx_decoder_if #(.CNT_W(32), .ERR_CNT_W(16)) bus();

  xgmii_tx_decoder #(.CNT_W(32), .ERR_CNT_W(16)) dut (
    .clkXGMIITx       (clk),
    .reset_xgmii_tx_n (rst_n),
    .bus              (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin : monitor
    exp_t got, e;
    if (bus.dec_val === 1'b1) begin
      got = {bus.dec_data, bus.dec_sop, bus.dec_eop, bus.dec_mod, bus.dec_err};
      prev_cyc = last_cyc;
      last_cyc = cyc;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL word_unexpected got data=%h sop=%b eop=%b mod=%0d err=%b required none",
                 got.data, got.sop, got.eop, got.mod, got.err);
      end else begin
        e = exp_q.pop_front();
        if (got !== e) begin
          errors++;
          $display("FAIL word got data=%h sop=%b eop=%b mod=%0d err=%b required data=%h sop=%b eop=%b mod=%0d err=%b",
                   got.data, got.sop, got.eop, got.mod, got.err, e.data, e.sop, e.eop, e.mod, e.err);
        end
      end
    end
  end

  initial begin : watchdog
    #300000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] req);
    checks++;
    if (got !== req) begin
      errors++;
      $display("FAIL %s got=%0h required=%0h", name, got, req);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_val"},  64'(bus.dec_val),   64'd0);
    check({tag, "_data"}, bus.dec_data,       64'd0);
    check({tag, "_sop"},  64'(bus.dec_sop),   64'd0);
    check({tag, "_eop"},  64'(bus.dec_eop),   64'd0);
    check({tag, "_mod"},  64'(bus.dec_mod),   64'd0);
    check({tag, "_err"},  64'(bus.dec_err),   64'd0);
    check({tag, "_fcnt"}, 64'(bus.frame_cnt), 64'd0);
    check({tag, "_ecnt"}, 64'(bus.err_cnt),   64'd0);
  endtask

  task automatic check_counters(input string tag);
    check({tag, "_frame_cnt"}, 64'(bus.frame_cnt), 64'(exp_frames));
    check({tag, "_err_cnt"},   64'(bus.err_cnt),   64'(exp_errs));
  endtask

  task automatic put(input bit c, input logic [7:0] b);
    strm.push_back({c, b});
  endtask

  task automatic idle_word();
    bus.xgmii_txc = 8'hFF;
    bus.xgmii_txd = {8{8'h07}};
  endtask

  // Payload bytes followed by a 4-byte FCS (reflected CRC-32, complemented, low byte first).
  task automatic make_frame(input int len, input int seed);
    logic [31:0] c;
    logic [7:0]  b;
    c = 32'hFFFF_FFFF;
    frm.delete();
    for (int i = 0; i < len - 4; i++) begin
      b = 8'((i * 13) + (seed * 29) + 5);
      frm.push_back(b);
      for (int j = 0; j < 8; j++) begin
        if (c[0] ^ b[j]) c = (c >> 1) ^ 32'hEDB88320;
        else             c = c >> 1;
      end
    end
    c = ~c;
    for (int j = 0; j < 4; j++) frm.push_back(c[8*j +: 8]);
  endtask

  task automatic add_pre0();
    put(1'b1, 8'hFB);
    for (int i = 0; i < 6; i++) put(1'b0, 8'h55);
    put(1'b0, 8'hD5);
  endtask

  task automatic add_pre4();
    for (int i = 0; i < 4; i++) put(1'b1, 8'h07);
    put(1'b1, 8'hFB);
    for (int i = 0; i < 6; i++) put(1'b0, 8'h55);
    put(1'b0, 8'hD5);
  endtask

  task automatic add_bytes(input int from, input int to);
    for (int i = from; i < to; i++) put(1'b0, frm[i]);
  endtask

  task automatic pad_idle();
    while (strm.size() % 8 != 0) put(1'b1, 8'h07);
    for (int i = 0; i < 8; i++) put(1'b1, 8'h07);
  endtask

  task automatic add_term();
    put(1'b1, 8'hFD);
    pad_idle();
  endtask

  task automatic push_exp(input int n, input bit bad);
    exp_t e;
    for (int i = 0; i < n; i += 8) begin
      e.data = '0;
      for (int k = 0; k < 8 && i + k < n; k++) e.data[63-8*k -: 8] = frm[i+k];
      e.sop = (i == 0);
      e.eop = (i + 8 >= n);
      e.mod = e.eop ? 3'(n % 8) : 3'd0;
      e.err = e.eop & bad;
      exp_q.push_back(e);
    end
  endtask

  task automatic drive_stream();
    logic [8:0] s;
    while (strm.size() >= 8) begin
      for (int l = 0; l < 8; l++) begin
        s = strm.pop_front();
        bus.xgmii_txc[l]         = s[8];
        bus.xgmii_txd[8*l +: 8]  = s[7:0];
      end
      @(posedge clk);
      #1;
    end
    idle_word();
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      @(posedge clk);
      #1;
      n++;
    end
    repeat (3) @(posedge clk);
    #1;
    check({name, "_drain"}, 64'(exp_q.size()), 64'd0);
  endtask

  task automatic good_frame(input int len, input int seed, input bit lane4, input string name);
    make_frame(len, seed);
    if (lane4) add_pre4();
    else       add_pre0();
    add_bytes(0, len);
    add_term();
    push_exp(len, 1'b0);
    exp_frames++;
    drive_stream();
    wait_drain(name);
    check_counters(name);
  endtask

  initial begin : stimulus
    exp_t e;
    idle_word();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // Lane-0 start, 64B: eight words, full eop word.
    good_frame(64, 1, 1'b0, "t1_lane0_64");
    // Lane-4 start, 60B: eop word holds 4 bytes.
    good_frame(60, 2, 1'b1, "t2_lane4_60");
    // 21B frame: terminate overflows staging, eop follows on the very next cycle.
    good_frame(21, 3, 1'b0, "t3_flush_21");
    check("t3_flush_gap", 64'(last_cyc - prev_cyc), 64'd1);

    // FE inside the third data word: eop err=1 on bytes 8..15, then a clean frame.
    make_frame(64, 4);
    add_pre0();
    add_bytes(0, 19);
    put(1'b1, 8'hFE);
    add_bytes(19, 23);
    pad_idle();
    push_exp(16, 1'b1);
    exp_errs++;
    drive_stream();
    wait_drain("t4_abort");
    check_counters("t4_abort");
    good_frame(64, 5, 1'b0, "t4_after");

    // Runt: start followed directly by terminate, nothing emitted.
    add_pre0();
    add_term();
    exp_errs++;
    drive_stream();
    wait_drain("runt");
    check_counters("runt");

    // One FCS bit flipped.
    make_frame(64, 1);
    frm[62] = frm[62] ^ 8'h10;
    add_pre0();
    add_bytes(0, 64);
    add_term();
    push_exp(64, CRC_EN);
    if (CRC_EN) exp_errs++;
    else        exp_frames++;
    drive_stream();
    wait_drain("t6_fcs_flip");
    check_counters("t6_fcs_flip");

    // Reset mid-frame after the first word has been emitted.
    make_frame(64, 6);
    add_pre0();
    add_bytes(0, 16);
    e.data = '0;
    for (int k = 0; k < 8; k++) e.data[63-8*k -: 8] = frm[k];
    e.sop = 1'b1;
    e.eop = 1'b0;
    e.mod = 3'd0;
    e.err = 1'b0;
    exp_q.push_back(e);
    drive_stream();
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check_all_zero("t5_reset");
    check("t5_pending", 64'(exp_q.size()), 64'd0);
    rst_n = 1'b1;
    exp_frames = 0;
    exp_errs = 0;
    repeat (4) @(posedge clk);
    #1;
    good_frame(64, 7, 1'b0, "t5_after");

    repeat (5) @(posedge clk);
    #1;
    check("final_pending", 64'(exp_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
